// File: rtl/calc_pkg.sv
// Shared calculator definitions: op codes, sequencer states, BCD digit width
// and a nibble validity helper.
package calc_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    OP_SUMA  = 3'd0,
    OP_RESTA = 3'd1,
    OP_MULT  = 3'd2,
    OP_DIV   = 3'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EXEC,
    MUL_IT,
    DIV_IT,
    DONE
  } state_e;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_addsub.sv
// Combinational DIGITS-digit packed-BCD adder/subtractor; carry_borrow is the
// carry out of the top digit (add) or the final borrow (sub).
module bcd_addsub
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      sub,
  output logic [DIGIT_W*DIGITS-1:0] y,
  output logic                      carry_borrow
);

  always_comb begin
    logic       c;
    logic [4:0] t;
    c = 1'b0;
    t = '0;
    y = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sub) begin
        t = {1'b0, a[i*DIGIT_W +: DIGIT_W]} - {1'b0, b[i*DIGIT_W +: DIGIT_W]} - {4'b0, c};
        c = t[4];
        if (c) t = t + 5'd10;
      end else begin
        t = {1'b0, a[i*DIGIT_W +: DIGIT_W]} + {1'b0, b[i*DIGIT_W +: DIGIT_W]} + {4'b0, c};
        c = (t > 5'd9);
        if (c) t = t - 5'd10;
      end
      y[i*DIGIT_W +: DIGIT_W] = t[3:0];
    end
    carry_borrow = c;
  end

endmodule

// File: rtl/alu_sequencer.sv
// BCD arithmetic sequencer: SUMA/RESTA in one pass, MULT/DIV iterated through
// one shared bcd_addsub. DIV support is built only when ALU_SEQ_DIV_EN is defined.
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset_in,
  input  logic                      start,
  input  logic                      abort,
  input  logic [2:0]                op_code,
  input  logic [DIGIT_W*DIGITS-1:0] lhs,
  input  logic [DIGIT_W*DIGITS-1:0] rhs,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] result,
  output logic [DIGIT_W*DIGITS-1:0] remainder,
  output logic                      neg,
  output logic                      error
);

  localparam int unsigned W = DIGIT_W * DIGITS;

  state_e       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] acc_q, acc_d, cnt_q, cnt_d;
  logic [W-1:0] result_q, result_d;
  logic         neg_q, neg_d, error_q, error_d;
  logic         busy_q, busy_d, done_q, done_d;

  logic [W-1:0] add_a, add_b, add_y;
  logic         add_sub, add_cb, swap;

`ifdef ALU_SEQ_DIV_EN
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [W-1:0] remainder_q, remainder_d;
`endif

  function automatic logic all_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) ok = ok & is_bcd(v[i*DIGIT_W +: DIGIT_W]);
    return ok;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_SUMA) || (op == OP_RESTA) || (op == OP_MULT) || (op == OP_DIV);
`else
    return (op == OP_SUMA) || (op == OP_RESTA) || (op == OP_MULT);
`endif
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         bw;
    r  = v;
    bw = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bw) begin
        if (v[i*DIGIT_W +: DIGIT_W] == 4'd0) begin
          r[i*DIGIT_W +: DIGIT_W] = 4'd9;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] - 4'd1;
          bw = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef ALU_SEQ_DIV_EN
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
          r[i*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
`endif

  // Packed BCD orders like binary, so a plain compare picks the larger
  // operand and RESTA yields its magnitude in a single adder pass.
  assign swap = (a_q < b_q);

  always_comb begin
    add_a   = acc_q;
    add_b   = a_q;
    add_sub = 1'b0;
    unique case (state_q)
      EXEC: begin
        if (op_q == OP_RESTA) begin
          add_sub = 1'b1;
          add_a   = swap ? b_q : a_q;
          add_b   = swap ? a_q : b_q;
        end else begin
          add_a = a_q;
          add_b = b_q;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      DIV_IT: begin
        add_a   = rem_q;
        add_b   = b_q;
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  bcd_addsub #(.DIGITS(DIGITS)) u_addsub (
    .a            (add_a),
    .b            (add_b),
    .sub          (add_sub),
    .y            (add_y),
    .carry_borrow (add_cb)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    error_d  = error_q;
`ifdef ALU_SEQ_DIV_EN
    rem_d       = rem_q;
    quo_d       = quo_q;
    remainder_d = remainder_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = lhs;
          b_d     = rhs;
          op_d    = op_code;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!all_bcd(a_q) || !all_bcd(b_q) || !op_legal(op_q) ||
            ((op_q == OP_DIV) && (b_q == '0))) begin
          result_d = '0;
          neg_d    = 1'b0;
          error_d  = 1'b1;
          state_d  = DONE;
        end else if (op_q == OP_MULT) begin
          acc_d   = '0;
          cnt_d   = b_q;
          state_d = MUL_IT;
        end
`ifdef ALU_SEQ_DIV_EN
        else if (op_q == OP_DIV) begin
          rem_d   = a_q;
          quo_d   = '0;
          state_d = DIV_IT;
        end
`endif
        else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        neg_d   = 1'b0;
        error_d = 1'b0;
        state_d = DONE;
        if (op_q == OP_RESTA) begin
          neg_d    = swap;
          result_d = add_y;
        end else if (add_cb) begin
          error_d  = 1'b1;
          result_d = '0;
        end else begin
          result_d = add_y;
        end
      end
      MUL_IT: begin
        if (cnt_q == '0) begin
          result_d = acc_q;
          neg_d    = 1'b0;
          error_d  = 1'b0;
          state_d  = DONE;
        end else if (add_cb) begin
          result_d = '0;
          neg_d    = 1'b0;
          error_d  = 1'b1;
          state_d  = DONE;
        end else begin
          acc_d = add_y;
          cnt_d = bcd_dec(cnt_q);
        end
      end
`ifdef ALU_SEQ_DIV_EN
      DIV_IT: begin
        if (add_cb) begin
          result_d    = quo_q;
          remainder_d = rem_q;
          neg_d       = 1'b0;
          error_d     = 1'b0;
          state_d     = DONE;
        end else begin
          rem_d = add_y;
          quo_d = bcd_inc(quo_q);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef ALU_SEQ_DIV_EN
    // Every completion except a successful divide reports a zero remainder.
    if ((state_d == DONE) && (state_q != DIV_IT)) remainder_d = '0;
    if (abort) remainder_d = '0;
`endif
    if (abort) begin
      state_d  = IDLE;
      result_d = '0;
      neg_d    = 1'b0;
      error_d  = 1'b0;
    end

    busy_d = state_d inside {CHECK, EXEC, MUL_IT, DIV_IT};
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rem_q       <= '0;
      quo_q       <= '0;
      remainder_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_DIV_EN
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      remainder_q <= remainder_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign neg    = neg_q;
  assign error  = error_q;
`ifdef ALU_SEQ_DIV_EN
  assign remainder = remainder_q;
`else
  assign remainder = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random ops checked
// against a decimal-arithmetic reference model.
module tb_alu_sequencer;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_in;
  logic        start;
  logic        abort;
  logic [2:0]  op_code;
  logic [15:0] lhs;
  logic [15:0] rhs;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] remainder;
  logic        neg;
  logic        error;

  int total = 0;
  int bad   = 0;

  alu_sequencer #(.DIGITS(4)) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .start     (start),
    .abort     (abort),
    .op_code   (op_code),
    .lhs       (lhs),
    .rhs       (rhs),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .neg       (neg),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit valid_bcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int m;
    m = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [2:0] op, input logic [15:0] l, input logic [15:0] r,
                       output logic [15:0] res, output logic [15:0] rem,
                       output logic ng, output logic er, output int lat);
    int a, b;
    res = '0; rem = '0; ng = 1'b0; er = 1'b0; lat = 2;
    if (!valid_bcd(l) || !valid_bcd(r) || op > 3'd3 ||
        (op == 3'd3 && (!DIV_EN || r == 16'h0000))) begin
      er = 1'b1;
      return;
    end
    a = bcd2int(l);
    b = bcd2int(r);
    case (op)
      3'd0: begin
        lat = 3;
        if (a + b > 9999) er = 1'b1;
        else res = int2bcd(a + b);
      end
      3'd1: begin
        lat = 3;
        if (a >= b) res = int2bcd(a - b);
        else begin res = int2bcd(b - a); ng = 1'b1; end
      end
      3'd2: begin
        if (a * b > 9999) begin
          er  = 1'b1;
          lat = 2 + (10000 + a - 1) / a;
        end else begin
          res = int2bcd(a * b);
          lat = 3 + b;
        end
      end
      default: begin
        res = int2bcd(a / b);
        rem = int2bcd(a % b);
        lat = 3 + a / b;
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] l,
                        input logic [15:0] r, input int poke_cyc);
    logic [15:0] e_res, e_rem;
    logic        e_neg, e_err;
    int          e_lat, cyc;
    model(op, l, r, e_res, e_rem, e_neg, e_err, e_lat);
    op_code = op; lhs = l; rhs = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < e_lat + 8) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke_cyc);
      if (start) begin lhs = 16'h1111; rhs = 16'h0001; op_code = 3'd0; end
    end
    start = 1'b0;
    check({tag, ".done"},      32'(done),      32'd1);
    check({tag, ".latency"},   32'(cyc),       32'(e_lat));
    check({tag, ".result"},    32'(result),    32'(e_res));
    check({tag, ".remainder"}, 32'(remainder), 32'(e_rem));
    check({tag, ".neg"},       32'(neg),       32'(e_neg));
    check({tag, ".error"},     32'(error),     32'(e_err));
    check({tag, ".busy_done"}, 32'(busy),      32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check({tag, ".quiet"}, {30'd0, done, busy}, 32'd0);
    end
    check({tag, ".held"}, 32'(result), 32'(e_res));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".done"},      32'(done),      32'd0);
    check({tag, ".result"},    32'(result),    32'd0);
    check({tag, ".remainder"}, 32'(remainder), 32'd0);
    check({tag, ".neg"},       32'(neg),       32'd0);
    check({tag, ".error"},     32'(error),     32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [15:0] rl, rr;
    int          idx;

    reset_in = 1'b0; start = 1'b0; abort = 1'b0;
    op_code = '0; lhs = '0; rhs = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    reset_in = 1'b1;
    @(posedge clk); #1;

    run_op("suma",      3'd0, 16'h1234, 16'h0766, 0);
    run_op("suma_ovf",  3'd0, 16'h9999, 16'h0001, 0);
    run_op("resta_neg", 3'd1, 16'h0005, 16'h0012, 0);
    run_op("resta_eq",  3'd1, 16'h0050, 16'h0050, 0);
    run_op("mult",      3'd2, 16'h0012, 16'h0003, 0);
    run_op("mult_ovf",  3'd2, 16'h5000, 16'h0002, 0);
    run_op("mult_zero", 3'd2, 16'h0777, 16'h0000, 0);
    run_op("div",       3'd3, 16'h0100, 16'h0007, 0);
    run_op("div_zero",  3'd3, 16'h0100, 16'h0000, 0);
    run_op("div_small", 3'd3, 16'h0003, 16'h0009, 0);
    run_op("nonbcd",    3'd0, 16'h00A1, 16'h0001, 0);
    run_op("illegal",   3'd5, 16'h0001, 16'h0001, 0);
    run_op("poke",      3'd2, 16'h0012, 16'h0003, 3);

    // abort mid-MULT after a RESTA left nonzero outputs
    run_op("pre_abort", 3'd1, 16'h0005, 16'h0012, 0);
    op_code = 3'd2; lhs = 16'h0001; rhs = 16'h0999; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort.busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_cleared("abort");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort.no_done", {30'd0, done, busy}, 32'd0);
    end

    // abort together with start in IDLE
    op_code = 3'd0; lhs = 16'h0001; rhs = 16'h0001; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start.busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_start.done", 32'(done), 32'd0);

    // reset in the middle of an operation
    run_op("pre_reset", 3'd0, 16'h1234, 16'h0766, 0);
    op_code = 3'd2; lhs = 16'h0002; rhs = 16'h0050; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_in = 1'b0;
    @(posedge clk); #1;
    reset_in = 1'b1;
    check_cleared("midreset");
    repeat (3) @(posedge clk);
    #1;
    check("midreset.no_done", {30'd0, done, busy}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 5));
      rl  = int2bcd(int'($urandom_range(0, 9999)));
      rr  = int2bcd(int'($urandom_range(0, 9999)));
      if (rop == 3'd2) begin
        rl = int2bcd(int'($urandom_range(0, 120)));
        rr = int2bcd(int'($urandom_range(0, 200)));
      end else if (rop == 3'd3) begin
        rr = ($urandom_range(0, 7) == 0) ? 16'h0000 : int2bcd(int'($urandom_range(20, 999)));
      end
      if ($urandom_range(0, 9) == 0) begin
        idx = int'($urandom_range(0, 3));
        rl[4*idx +: 4] = 4'($urandom_range(10, 15));
      end
      run_op($sformatf("rand%0d", n), rop, rl, rr, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
